// File: rtl/vga_dither.sv
// Ordered-dither output stage between the video core and a low-depth resistor DAC.
// A 4x4 Bayer threshold is added per channel with saturation and then truncated; 2 clk latency on every output.
module vga_dither #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 3,
    parameter int TEMPORAL = 1,
    parameter int SYNC_POL = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pixel_ce,
    input  logic [IN_BITS-1:0]  red_in,
    input  logic [IN_BITS-1:0]  green_in,
    input  logic [IN_BITS-1:0]  blue_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                window_in,
    output logic [OUT_BITS-1:0] red_out,
    output logic [OUT_BITS-1:0] green_out,
    output logic [OUT_BITS-1:0] blue_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                window_out
);

    localparam int   R         = IN_BITS - OUT_BITS;
    localparam logic SYNC_ACT  = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = ~SYNC_ACT;

    logic [1:0] xcnt_reg, xcnt_next;
    logic [1:0] ycnt_reg, ycnt_next;
    logic [1:0] frame_reg, frame_next;
    logic       hs_d1_reg, vs_d1_reg, win_d1_reg;
    logic       hs_d2_reg, vs_d2_reg, win_d2_reg;

    logic       vs_edge;
    logic       win_fall;
    logic [1:0] col;
    logic [3:0] thresh;
    logic [IN_BITS:0] ts;

    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] c);
        logic [3:0] t;
        case ({row, c})
            4'h0: t = 4'd0;   4'h1: t = 4'd8;   4'h2: t = 4'd2;   4'h3: t = 4'd10;
            4'h4: t = 4'd12;  4'h5: t = 4'd4;   4'h6: t = 4'd14;  4'h7: t = 4'd6;
            4'h8: t = 4'd3;   4'h9: t = 4'd11;  4'ha: t = 4'd1;   4'hb: t = 4'd9;
            4'hc: t = 4'd15;  4'hd: t = 4'd7;   4'he: t = 4'd13;  default: t = 4'd5;
        endcase
        return t;
    endfunction

    // The stage-1 sync/window copies double as the edge-detect history.
    assign vs_edge  = (vs_d1_reg == SYNC_IDLE) && (vsync_in == SYNC_ACT);
    assign win_fall = win_d1_reg && !window_in;
    assign col      = xcnt_reg + frame_reg;
    assign thresh   = bayer(ycnt_reg, col);
    assign ts       = {{(IN_BITS - 3){1'b0}}, thresh} << (R - 4);

    always_comb begin
        xcnt_next  = xcnt_reg;
        ycnt_next  = ycnt_reg;
        frame_next = frame_reg;
        if (!window_in)
            xcnt_next = 2'd0;
        else if (pixel_ce)
            xcnt_next = xcnt_reg + 2'd1;
        if (vs_edge)
            ycnt_next = 2'd0;
        else if (win_fall)
            ycnt_next = ycnt_reg + 2'd1;
        if (vs_edge && (TEMPORAL != 0))
            frame_next = frame_reg + 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xcnt_reg   <= 2'd0;
            ycnt_reg   <= 2'd0;
            frame_reg  <= 2'd0;
            hs_d1_reg  <= SYNC_IDLE;
            vs_d1_reg  <= SYNC_IDLE;
            win_d1_reg <= 1'b0;
            hs_d2_reg  <= SYNC_IDLE;
            vs_d2_reg  <= SYNC_IDLE;
            win_d2_reg <= 1'b0;
        end else begin
            xcnt_reg   <= xcnt_next;
            ycnt_reg   <= ycnt_next;
            frame_reg  <= frame_next;
            hs_d1_reg  <= hsync_in;
            vs_d1_reg  <= vsync_in;
            win_d1_reg <= window_in;
            hs_d2_reg  <= hs_d1_reg;
            vs_d2_reg  <= vs_d1_reg;
            win_d2_reg <= win_d1_reg;
        end
    end

    logic [IN_BITS-1:0] chan_in [3];
    assign chan_in[0] = red_in;
    assign chan_in[1] = green_in;
    assign chan_in[2] = blue_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_ch
            logic [IN_BITS:0]    sum;
            logic [IN_BITS-1:0]  sat;
            logic [OUT_BITS-1:0] s1_reg;
            logic [OUT_BITS-1:0] s2_reg;

            assign sum = {1'b0, chan_in[gi]} + ts;
            assign sat = sum[IN_BITS] ? {IN_BITS{1'b1}} : sum[IN_BITS-1:0];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_reg <= '0;
                    s2_reg <= '0;
                end else begin
                    s1_reg <= sat[IN_BITS-1:R];
                    s2_reg <= win_d1_reg ? s1_reg : '0;
                end
            end
        end
    endgenerate

    assign red_out    = gen_ch[0].s2_reg;
    assign green_out  = gen_ch[1].s2_reg;
    assign blue_out   = gen_ch[2].s2_reg;
    assign hsync_out  = hs_d2_reg;
    assign vsync_out  = vs_d2_reg;
    assign window_out = win_d2_reg;

endmodule

// File: tb/tb_vga_dither.sv
// Bench for vga_dither: a static-pattern and a temporal instance share stimulus from a vector table;
// reset behaviour is exercised by hand-written sequences.
module tb_vga_dither;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_ce = 1'b0;
    logic [7:0] red_in = 8'hFF, green_in = 8'hFF, blue_in = 8'hFF;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, window_in = 1'b0;

    logic [2:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic       hs_a, vs_a, win_a, hs_b, vs_b, win_b;

    always #5 clk = ~clk;

    vga_dither #(.IN_BITS(8), .OUT_BITS(3), .TEMPORAL(0), .SYNC_POL(0)) dut_a (
        .clk(clk), .reset(reset), .pixel_ce(pixel_ce),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .window_in(window_in),
        .red_out(red_a), .green_out(green_a), .blue_out(blue_a),
        .hsync_out(hs_a), .vsync_out(vs_a), .window_out(win_a)
    );

    vga_dither #(.IN_BITS(8), .OUT_BITS(3), .TEMPORAL(1), .SYNC_POL(0)) dut_b (
        .clk(clk), .reset(reset), .pixel_ce(pixel_ce),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .window_in(window_in),
        .red_out(red_b), .green_out(green_b), .blue_out(blue_b),
        .hsync_out(hs_b), .vsync_out(vs_b), .window_out(win_b)
    );

    typedef struct {
        logic [7:0] r, g, b;
        logic       hs, vs, win, ce;
        logic [8:0] e0;   // expected {r,g,b} for the static instance
        logic [8:0] e1;   // expected {r,g,b} for the temporal instance
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    // Hand-computed 3-bit outputs for flat inputs 0x10 and 0x0C, indexed row*4+col.
    int p10 [16] = '{0,1,0,1, 1,0,1,0, 0,1,0,1, 1,0,1,0};
    int p0c [16] = '{0,0,0,1, 1,0,1,0, 0,1,0,0, 1,0,1,0};

    // Stimulus-side position tracking used to pick the table entry for each pixel.
    int   gx = 0, gy = 0, ge = 0;
    logic gpw = 1'b0, gpv = 1'b1;

    function automatic logic [2:0] ch_exp(input logic [7:0] v, input int row, input int c);
        if (v == 8'h00) return 3'd0;
        if (v == 8'hFF) return 3'd7;
        if (v == 8'h10) return 3'(p10[row*4 + c]);
        return 3'(p0c[row*4 + c]);
    endfunction

    task automatic add_vec(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic hs, input logic vs, input logic win, input logic ce);
        vec_t v;
        int   c0, c1;
        c0 = gx;
        c1 = (gx + ge) % 4;
        v.r = r; v.g = g; v.b = b;
        v.hs = hs; v.vs = vs; v.win = win; v.ce = ce;
        v.e0 = win ? {ch_exp(r, gy, c0), ch_exp(g, gy, c0), ch_exp(b, gy, c0)} : 9'd0;
        v.e1 = win ? {ch_exp(r, gy, c1), ch_exp(g, gy, c1), ch_exp(b, gy, c1)} : 9'd0;
        vq.push_back(v);
        if (gpv && !vs) begin
            ge = ge + 1;
            gy = 0;
        end else if (gpw && !win) begin
            gy = (gy + 1) % 4;
        end
        if (!win) gx = 0;
        else if (ce) gx = (gx + 1) % 4;
        gpw = win;
        gpv = vs;
    endtask

    task automatic blank(input int n, input logic hs, input logic vs);
        for (int k = 0; k < n; k++) add_vec(8'hFF, 8'hFF, 8'hFF, hs, vs, 1'b0, 1'b1);
    endtask

    task automatic line(input int n, input logic [7:0] g, input logic ce_alt);
        for (int k = 0; k < n; k++)
            add_vec(8'h10, g, 8'h0C, 1'b1, 1'b1, 1'b1, ce_alt ? logic'(k % 2) : 1'b1);
    endtask

    task automatic hblank();
        blank(2, 1'b0, 1'b1);
        blank(2, 1'b1, 1'b1);
    endtask

    task automatic vpulse();
        blank(1, 1'b1, 1'b1);
        blank(2, 1'b1, 1'b0);
        blank(1, 1'b1, 1'b1);
    endtask

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got={rgb,hs,vs,win}=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        red_in = v.r; green_in = v.g; blue_in = v.b;
        hsync_in = v.hs; vsync_in = v.vs; window_in = v.win; pixel_ce = v.ce;
    endtask

    // Apply the queued vectors one per clk; each is checked two clocks after it is applied.
    task automatic run_vecs(input string seg);
        int n;
        n = vq.size();
        for (int i = 0; i < n + 2; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                chk($sformatf("%s_v%0d_static", seg, i - 2),
                    {red_a, green_a, blue_a, hs_a, vs_a, win_a},
                    {vq[i-2].e0, vq[i-2].hs, vq[i-2].vs, vq[i-2].win});
                chk($sformatf("%s_v%0d_temporal", seg, i - 2),
                    {red_b, green_b, blue_b, hs_b, vs_b, win_b},
                    {vq[i-2].e1, vq[i-2].hs, vq[i-2].vs, vq[i-2].win});
            end
            if (i < n) drive(vq[i]);
        end
        vq.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_static",   {red_a, green_a, blue_a, hs_a, vs_a, win_a}, 12'b000000000_110);
        chk("reset_temporal", {red_b, green_b, blue_b, hs_b, vs_b, win_b}, 12'b000000000_110);
        #2 reset = 1'b0;

        blank(3, 1'b1, 1'b1);
        vpulse();
        for (int yy = 0; yy < 4; yy++) begin
            line(8, (yy % 2 == 1) ? 8'hFF : 8'h00, 1'b0);
            hblank();
        end
        line(8, 8'hFF, 1'b0);
        hblank();
        line(6, 8'h00, 1'b0);
        // window falls on the same clk as the vsync active edge: the row clear must win
        add_vec(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        blank(2, 1'b1, 1'b0);
        blank(1, 1'b1, 1'b1);
        line(8, 8'hFF, 1'b0);
        hblank();
        line(8, 8'h00, 1'b1);
        hblank();
        vpulse();
        vpulse();
        line(8, 8'hFF, 1'b0);
        hblank();
        for (int k = 0; k < 8; k++)
            add_vec(8'hFF, 8'hFF, 8'hFF, logic'(k % 2), logic'((k / 2) % 2), 1'b0, 1'b1);
        while ((ge % 4) != 3) vpulse();
        blank(2, 1'b1, 1'b1);
        run_vecs("main");

        // Mid-line reset with xcnt=2 and temporal frame=3.
        @(posedge clk);
        #1;
        red_in = 8'hFF; green_in = 8'hFF; blue_in = 8'h10;
        hsync_in = 1'b1; vsync_in = 1'b1; window_in = 1'b1; pixel_ce = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_static",   {red_a, green_a, 3'd0, hs_a, vs_a, win_a}, 12'b111111000_111);
        chk("pre_reset_temporal", {red_b, green_b, 3'd0, hs_b, vs_b, win_b}, 12'b111111000_111);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_static",   {red_a, green_a, blue_a, hs_a, vs_a, win_a}, 12'b000000000_110);
        chk("async_reset_temporal", {red_b, green_b, blue_b, hs_b, vs_b, win_b}, 12'b000000000_110);
        window_in = 1'b0; pixel_ce = 1'b0;
        @(posedge clk);
        #1;
        chk("held_reset_static",   {red_a, green_a, blue_a, hs_a, vs_a, win_a}, 12'b000000000_110);
        chk("held_reset_temporal", {red_b, green_b, blue_b, hs_b, vs_b, win_b}, 12'b000000000_110);
        #2 reset = 1'b0;

        gx = 0; gy = 0; ge = 0; gpw = 1'b0; gpv = 1'b1;
        line(8, 8'hFF, 1'b0);
        hblank();
        line(4, 8'h00, 1'b0);
        blank(2, 1'b1, 1'b1);
        run_vecs("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
